// File: rtl/sbox_scheduler.sv
// Time-shared AES SubBytes engine: LANES S-box lookups per cycle, arbitrated
// round-robin between a 16-byte state job and a 4-byte key-word job.
// Define SBOX_INV_EN to add the inverse S-box for state jobs (selected by st_inv).
module sbox_scheduler #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_in,
    input  logic         st_inv,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("sbox_scheduler: LANES must be 1, 2 or 4");
    end

    // Row r of each table holds entries 16r..16r+15; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SBOX_INV_EN
    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    logic use_inv;
`else
    logic unused_st_inv;
    assign unused_st_inv = st_inv;
`endif

    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW, DONE} state_t;
    typedef enum logic {JOB_ST, JOB_KW} job_t;

    state_t       state, state_nxt;
    job_t         job, last_grant;
    logic [3:0]   cnt;
    logic [127:0] work, work_nxt;
    logic         grant_st, grant_kw, last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        grant_st  = 1'b0;
        grant_kw  = 1'b0;
        last_step = (state == RUN_ST && cnt == 4'(16 - LANES)) ||
                    (state == RUN_KW && cnt == 4'(4 - LANES));
        case (state)
            IDLE: begin
                if (st_req && kw_req) begin
                    if (last_grant == JOB_ST) grant_kw = 1'b1;
                    else                      grant_st = 1'b1;
                end else begin
                    grant_st = st_req;
                    grant_kw = kw_req;
                end
                if (grant_st)      state_nxt = RUN_ST;
                else if (grant_kw) state_nxt = RUN_KW;
            end
            RUN_ST, RUN_KW: if (last_step) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign st_done = (state == DONE) && (job == JOB_ST);
    assign kw_done = (state == DONE) && (job == JOB_KW);

    // In-place substitution of bytes cnt..cnt+LANES-1; word jobs live in work[31:0].
    always_comb begin
        logic [3:0] idx;
        work_nxt = work;
        idx      = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = cnt + 4'(l);
`ifdef SBOX_INV_EN
            work_nxt[{idx, 3'b000} +: 8] = use_inv ? SBOX_INV[work[{idx, 3'b000} +: 8]]
                                                   : SBOX_FWD[work[{idx, 3'b000} +: 8]];
`else
            work_nxt[{idx, 3'b000} +: 8] = SBOX_FWD[work[{idx, 3'b000} +: 8]];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            work       <= '0;
            job        <= JOB_ST;
            last_grant <= JOB_ST;
            st_out     <= '0;
            kw_out     <= '0;
`ifdef SBOX_INV_EN
            use_inv    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_st) begin
                        work <= st_in;
                        job  <= JOB_ST;
`ifdef SBOX_INV_EN
                        use_inv <= st_inv;
`endif
                    end else if (grant_kw) begin
                        work <= {96'b0, kw_in};
                        job  <= JOB_KW;
`ifdef SBOX_INV_EN
                        use_inv <= 1'b0;
`endif
                    end
                end
                RUN_ST, RUN_KW: begin
                    work <= work_nxt;
                    cnt  <= cnt + 4'(LANES);
                    // Outputs load on the final substitution edge so they are valid with done.
                    if (last_step) begin
                        if (state == RUN_ST) st_out <= work_nxt;
                        else                 kw_out <= work_nxt[31:0];
                    end
                end
                DONE: begin
                    last_grant <= job;
                    cnt        <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: LANES=4 main instance plus a LANES=1 instance
// for the serial-latency case. Expected bytes are hand-looked-up AES S-box values.
module tb_sbox_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         st_req, st_inv, kw_req, st_done, kw_done, busy;
    logic [127:0] st_in, st_out;
    logic [31:0]  kw_in, kw_out;

    logic         st_req1, st_inv1, kw_req1, st_done1, kw_done1, busy1;
    logic [127:0] st_in1, st_out1;
    logic [31:0]  kw_in1, kw_out1;

    sbox_scheduler #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .st_req(st_req), .st_in(st_in), .st_inv(st_inv), .st_done(st_done), .st_out(st_out),
        .kw_req(kw_req), .kw_in(kw_in), .kw_done(kw_done), .kw_out(kw_out), .busy(busy)
    );

    sbox_scheduler #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_req(st_req1), .st_in(st_in1), .st_inv(st_inv1), .st_done(st_done1), .st_out(st_out1),
        .kw_req(kw_req1), .kw_in(kw_in1), .kw_done(kw_done1), .kw_out(kw_out1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts rising edges from the first one (the grant edge) until done is seen.
    // sel: 0 = st_done, 1 = kw_done, 2 = st_done1. lat = -1 on timeout.
    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel == 0 && st_done) || (sel == 1 && kw_done) || (sel == 2 && st_done1))
                return;
        end
        lat = -1;
    endtask

    int   lat;
    int   n_done;
    int   done_at [3];
    logic done_kw [3];
    logic busy_at [16];
    int   pulses;

    initial begin
        st_req = 0; st_inv = 0; st_in = '0; kw_req = 0; kw_in = '0;
        st_req1 = 0; st_inv1 = 0; st_in1 = '0; kw_req1 = 0; kw_in1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_busy",    busy,    0);
        check("rst_st_done", st_done, 0);
        check("rst_kw_done", kw_done, 0);
        check("rst_st_out",  st_out,  0);
        check("rst_kw_out",  kw_out,  0);

        // Word job
        kw_in = 32'h580d7a12; kw_req = 1;
        wait_done(1, lat);
        kw_req = 0;
        check("kw_lat", lat, 2);
        check("kw_out", kw_out, 32'h6ad7dac9);
        check("kw_keeps_st_out", st_out, 0);
        @(negedge clk);

        // State job, LANES=4
        st_in = {8'h53, 120'h0}; st_req = 1;
        wait_done(0, lat);
        st_req = 0;
        check("st_lat", lat, 5);
        check("st_out", st_out, {8'hed, {15{8'h63}}});
        check("st_keeps_kw_out", kw_out, 32'h6ad7dac9);
        @(negedge clk);

        // State job, LANES=1
        st_in1 = {8'h53, 120'h0}; st_req1 = 1;
        wait_done(2, lat);
        st_req1 = 0;
        check("st1_lat", lat, 17);
        check("st1_out", st_out1, {8'hed, {15{8'h63}}});
        @(negedge clk);

        // Round robin from reset, both requests held for three jobs
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        st_in = '0; kw_in = '0; st_req = 1; kw_req = 1;
        n_done = 0;
        for (int n = 1; n <= 15 && n_done < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            busy_at[n] = busy;
            if (st_done || kw_done) begin
                done_at[n_done] = n;
                done_kw[n_done] = kw_done;
                n_done++;
            end
        end
        st_req = 0; kw_req = 0;
        check("rr_count",   n_done, 3);
        check("rr0_kw",     done_kw[0], 1);
        check("rr0_at",     done_at[0], 2);
        check("rr1_kw",     done_kw[1], 0);
        check("rr1_at",     done_at[1], 8);
        check("rr2_kw",     done_kw[2], 1);
        check("rr2_at",     done_at[2], 11);
        check("rr_idle3",   busy_at[3], 0);
        check("rr_busy4",   busy_at[4], 1);
        check("rr_idle9",   busy_at[9], 0);
        check("rr_st_out",  st_out, {16{8'h63}});
        check("rr_kw_out",  kw_out, 32'h63636363);
        @(negedge clk);

        // Input changed and request dropped after capture
        st_in = {16{8'h53}}; st_req = 1;
        @(posedge clk);
        @(negedge clk);
        st_in = {16{8'h12}}; st_req = 0;
        wait_done(0, lat);
        check("cap_lat", lat, 4);
        check("cap_out", st_out, {16{8'hed}});
        @(negedge clk);

        // Reset during RUN_ST cycle 2
        st_in = '0; st_req = 1;
        @(posedge clk);
        @(negedge clk);
        st_req = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("abort_busy",    busy,    0);
        check("abort_st_done", st_done, 0);
        check("abort_st_out",  st_out,  0);
        @(negedge clk);
        rst_n = 1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (st_done || busy) pulses++;
        end
        check("abort_quiet", pulses, 0);
        kw_in = 32'hc9c9c9c9; kw_req = 1;
        wait_done(1, lat);
        kw_req = 0;
        check("post_kw_lat", lat, 2);
        check("post_kw_out", kw_out, 32'hdddddddd);
        @(negedge clk);

        // Inverse select on a state job
        st_inv = 1; st_in = {16{8'hc9}}; st_req = 1;
        wait_done(0, lat);
        st_req = 0; st_inv = 0;
        check("inv_lat", lat, 5);
`ifdef SBOX_INV_EN
        check("inv_out", st_out, {16{8'h12}});
`else
        check("inv_out", st_out, {16{8'hdd}});
`endif
        check("inv_kw_out", kw_out, 32'hdddddddd);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
